// File: rtl/mul_issue_ctrl.sv
// Round-robin issue control for the shared multiplier with a credit-protected result FIFO.
// Optional MUL_STALL_CNT_EN adds a saturating stall_cnt output.
module mul_issue_ctrl #(
  parameter int NUM_RS     = 3,
  parameter int TAG_W      = 4,
  parameter int LAT        = 3,
  parameter int OBUF_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_RS-1:0]       rs_req,
  input  logic [NUM_RS*TAG_W-1:0] rs_tag,
  input  logic [NUM_RS*32-1:0]    rs_opa,
  input  logic [NUM_RS*32-1:0]    rs_opb,
  output logic [NUM_RS-1:0]       rs_gnt,
  output logic [31:0]             mul_a,
  output logic [31:0]             mul_b,
  input  logic [63:0]             mul_p,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [63:0]             cdb_data,
  input  logic                    cdb_ready,
  output logic                    busy
`ifdef MUL_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int FP_W  = $clog2(OBUF_DEPTH);
  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OBUF_DEPTH);
  localparam logic [PTR_W-1:0] RS_LAST = PTR_W'(NUM_RS - 1);
  localparam logic [FP_W-1:0]  FP_LAST = FP_W'(OBUF_DEPTH - 1);

  logic [PTR_W-1:0] rr_q, rr_d, gidx;
  logic             found, allow;
  int               idx;

  logic             iss_vld_q;
  logic [TAG_W-1:0] iss_tag_q;
  logic [31:0]      a_q, b_q;

  logic [LAT-1:0]   pv_q;
  logic [TAG_W-1:0] ptag_q [LAT];
  logic [63:0]      pdat_q [LAT];

  logic [TAG_W-1:0] ftag_q [OBUF_DEPTH];
  logic [63:0]      fdat_q [OBUF_DEPTH];
  logic [FP_W-1:0]  wp_q, rp_q;
  logic [CNT_W-1:0] fcnt_q, cnt_q;

  logic push, pop, nempty;

  // Reset also gates the grant so nothing is offered while held in reset.
  always_comb begin
    allow  = rst_n && (cnt_q < DEPTH_C) && !flush;
    rs_gnt = '0;
    gidx   = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_RS; k++) begin
      idx = (int'(rr_q) + k) % NUM_RS;
      if (allow && !found && rs_req[idx]) begin
        found       = 1'b1;
        rs_gnt[idx] = 1'b1;
        gidx        = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (found) begin
      rr_d = (gidx == RS_LAST) ? '0 : gidx + 1'b1;
    end
  end

  assign nempty    = (fcnt_q != '0);
  assign push      = pv_q[LAT-1];
  assign pop       = nempty && cdb_ready && !flush;
  assign cdb_valid = nempty;
  assign cdb_tag   = nempty ? ftag_q[rp_q] : '0;
  assign cdb_data  = nempty ? fdat_q[rp_q] : '0;
  assign busy      = (cnt_q != '0);
  assign mul_a     = a_q;
  assign mul_b     = b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      iss_vld_q <= 1'b0;
      iss_tag_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      pv_q      <= '0;
      for (int i = 0; i < LAT; i++) begin
        ptag_q[i] <= '0;
        pdat_q[i] <= '0;
      end
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        ftag_q[i] <= '0;
        fdat_q[i] <= '0;
      end
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      iss_vld_q <= 1'b0;
      pv_q      <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      fcnt_q    <= '0;
      cnt_q     <= '0;
    end else begin
      rr_q      <= rr_d;
      iss_vld_q <= found;
      if (found) begin
        iss_tag_q <= rs_tag[int'(gidx)*TAG_W +: TAG_W];
        a_q       <= rs_opa[int'(gidx)*32 +: 32];
        b_q       <= rs_opb[int'(gidx)*32 +: 32];
      end
      // Stages never stall: credit reserves a FIFO slot per issue.
      pv_q[0]   <= iss_vld_q;
      ptag_q[0] <= iss_tag_q;
      pdat_q[0] <= mul_p;
      for (int i = 1; i < LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        ptag_q[i] <= ptag_q[i-1];
        pdat_q[i] <= pdat_q[i-1];
      end
      if (push) begin
        ftag_q[wp_q] <= ptag_q[LAT-1];
        fdat_q[wp_q] <= pdat_q[LAT-1];
        wp_q         <= (wp_q == FP_LAST) ? '0 : wp_q + 1'b1;
      end
      if (pop) begin
        rp_q <= (rp_q == FP_LAST) ? '0 : rp_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
      unique case ({found, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef MUL_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall_ev;

  assign stall_ev = ((|rs_req) && !found && !flush)
                  || (nempty && !cdb_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if (stall_ev && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Issue controller for the shared 32x32 Wallace-tree multiplier inside the execution cluster. Arbitrates round-robin among the multiply reservation stations and drives registered operands into the combinational multiplier. Carries each product with its tag through a LAT-stage result pipeline, then buffers results in a credit-protected FIFO until the CDB accepts them.

Parameters:
NUM_RS, 3, number of requesting reservation stations
TAG_W, 4, reservation-station tag width
LAT, 3, result pipeline stages after the multiplier, 1 or more
OBUF_DEPTH, 8, result FIFO entries and total in-flight credit limit; must be 2 or more

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all in-flight and buffered work
rs_req  in  NUM_RS  per-station request, operands ready
rs_tag  in  NUM_RS*TAG_W  per-station tag, station i at [i*TAG_W +: TAG_W]
rs_opa  in  NUM_RS*32  per-station operand A
rs_opb  in  NUM_RS*32  per-station operand B
rs_gnt  out  NUM_RS  one-hot grant, combinational
mul_a  out  32  registered operand A to the multiplier
mul_b  out  32  registered operand B to the multiplier
mul_p  in  64  multiplier product, combinational from mul_a/mul_b
cdb_valid  out  1  result available
cdb_tag  out  TAG_W  result tag
cdb_data  out  64  result product
cdb_ready  in  1  CDB accepts the result
busy  out  1  credit count is nonzero

Behaviour:
Reset (rst_n low, asynchronous):
- rs_gnt=0, mul_a=0, mul_b=0, cdb_valid=0, cdb_tag=0, cdb_data=0, busy=0.
- Issue valid, all pipe valids, FIFO pointers and credit count cleared; round-robin pointer=0.
- Reset mid-operation drops all work; nothing is replayed.

Arbitration:
- Grant allowed only if credit count < OBUF_DEPTH and flush=0.
- If allowed, rs_gnt is one-hot on the first asserted rs_req searching from rr_ptr upward, with wrap-around. Otherwise rs_gnt=0.
- After a grant to station i, rr_ptr becomes (i+1) mod NUM_RS. With no grant, rr_ptr is unchanged.
- The station drops or replaces its request in the cycle after the grant.

Pipeline timing (grant in cycle T):
- T+1: mul_a, mul_b and the issue tag/valid registers are loaded.
- End of T+1: mul_p is sampled into pipe stage 1 with tag and valid.
- Data shifts one stage per cycle; stages never stall, because credit guarantees FIFO space.
- End of cycle T+1+LAT: entry written to the FIFO.
- cdb_valid rises no earlier than T+2+LAT (T+5 at defaults).
- mul_a/mul_b hold their last value when there is no issue.

FIFO and CDB:
- cdb_valid = FIFO not empty; cdb_tag/cdb_data show the FIFO head.
- Pop when cdb_valid && cdb_ready. Head is held stable while cdb_ready=0.
- FIFO pointers wrap modulo OBUF_DEPTH.

Credit count:
- +1 on grant, -1 on pop, unchanged when both occur in the same cycle.
- Never exceeds OBUF_DEPTH, never goes below 0.
- busy = (count != 0).

Flush:
- Synchronous, takes effect at the next edge.
- Clears issue valid, pipe valids, FIFO pointers and count; rr_ptr is kept.
- No grant and no pop in the flush cycle; cdb_valid=0 from the next cycle.

Optional Feature:
MUL_STALL_CNT_EN
- Defined: adds output stall_cnt (32 bits), reset 0, synchronous clear on flush.
- stall_cnt increments, saturating at all-ones, in each cycle where (|rs_req) && rs_gnt==0 && flush==0.
- Also increments in each cycle where cdb_valid && !cdb_ready.
- If both conditions hold in one cycle, it increments by 1 only.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Single op: rs_req=3'b001, opa=0xFFFFFFFF, opb=0xFFFFFFFF, tag=5, cdb_ready=1 at cycle T -> rs_gnt=001 at T; cdb_valid at T+5 with cdb_data=0xFFFFFFFE00000001, cdb_tag=5, high for one cycle; busy back to 0 after the pop.
- Round-robin: rs_req=3'b111 held for 6 cycles with ready stations -> grants 001,010,100,001,010,100; results leave in that order, one per cycle.
- Backpressure: cdb_ready=0, all stations requesting continuously -> exactly 8 grants, then rs_gnt=0 and busy=1. Raising cdb_ready -> 8 results in grant order, head stable while stalled, then grants resume.
- Simultaneous grant and pop at count=8 is impossible; at count=7 with a grant and a pop in the same cycle -> count stays 7.
- Flush with 3 ops in the pipe and 2 in the FIFO -> cdb_valid=0 the next cycle, busy=0, no stale results later. A new request is granted in the cycle after the flush.
- Reset asserted asynchronously mid-stream -> all outputs 0 immediately. After release, the first rs_req=3'b100 is granted even though rr_ptr was previously nonzero (pointer reset to 0, search wraps).
